// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache in front of a slow
// backing instruction memory. Hits return the instruction combinationally;
// a miss stalls fetch and refills one line, one word at a time, in order.
//
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   pc              fetch address (bits [1:0] ignored)
//   instr, stall    looked-up instruction (0 while stalled) and stall flag
//   flush           invalidate every line (fence.i)
//   mem_req/addr    word read request toward backing memory
//   mem_valid/rdata returned word, accepted on the edge where mem_valid=1
module icache #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     stall,
    input  logic                     flush,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_valid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int unsigned WORD_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned OFF_W  = WORD_W + 2;
    localparam int unsigned TAG_W  = ADDRESS_WIDTH - IDX_W - OFF_W;
    localparam int unsigned SLOTS  = LINES * WORDS_PER_LINE;

    typedef enum logic {
        S_IDLE,
        S_REFILL
    } state_e;

    state_e                        state_q, state_d;
    logic [LINES-1:0]              valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0]   tag_q, tag_d;
    logic [ADDRESS_WIDTH-1:0]      line_base_q, line_base_d;
    logic [WORD_W-1:0]             beat_q, beat_d;
    logic                          flushed_q, flushed_d;
    logic                          data_we;
    logic [DATA_WIDTH-1:0]         data_q [SLOTS];

    // Address fields of the current fetch and of the line being refilled
    logic [WORD_W-1:0] pc_word;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              unused_pc_bits;

    assign pc_word        = pc[2 +: WORD_W];
    assign pc_idx         = pc[OFF_W +: IDX_W];
    assign pc_tag         = pc[ADDRESS_WIDTH-1 -: TAG_W];
    assign fill_idx       = line_base_q[OFF_W +: IDX_W];
    assign fill_tag       = line_base_q[ADDRESS_WIDTH-1 -: TAG_W];
    assign unused_pc_bits = ^pc[1:0];

    // Lookup is only trusted while no refill is in progress
    assign hit   = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && (state_q == S_IDLE);
    assign stall = !hit;
    assign instr = hit ? data_q[{pc_idx, pc_word}] : '0;

    // Request outputs come straight from flops, so reset clears them at once
    assign mem_req  = (state_q == S_REFILL);
    assign mem_addr = line_base_q + ADDRESS_WIDTH'({beat_q, 2'b00});

    // Next-state logic for the refill FSM and the valid/tag arrays
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        line_base_d = line_base_q;
        beat_d      = beat_q;
        flushed_d   = flushed_q;
        data_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    line_base_d     = {pc_tag, pc_idx, OFF_W'(0)};
                    valid_d[pc_idx] = 1'b0;
                    beat_d          = '0;
                    state_d         = S_REFILL;
                end
            end
            S_REFILL: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (mem_valid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + WORD_W'(1);
                    if (beat_q == WORD_W'(WORDS_PER_LINE - 1)) begin
                        tag_d[fill_idx]   = fill_tag;
                        // A flush seen at any point of the refill leaves the line invalid
                        valid_d[fill_idx] = !(flushed_q || flush);
                        flushed_d         = 1'b0;
                        state_d           = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over any valid bit set this cycle
        if (flush) begin
            valid_d = '0;
        end
    end

    // Control state, valid bits and tags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            tag_q       <= '0;
            line_base_q <= '0;
            beat_q      <= '0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            line_base_q <= line_base_d;
            beat_q      <= beat_d;
            flushed_q   <= flushed_d;
        end
    end

    // Data array, not reset; contents only observed behind a valid bit
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[{fill_idx, beat_q}] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int wait_cycles = 0;
    int wcnt = 0;

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_instr_q [$];

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .instr     (instr),
        .stall     (stall),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory contents: lines with addr[8] set hold 0xB0.., others 0xA0..
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[8] ? 8'hB0 : 8'hA0;
        return {24'h0, b | {6'b0, a[3:2]}};
    endfunction

    // Monitor + memory responder: scoreboards instructions and request addresses
    always @(negedge clk) begin
        if (!stall && exp_instr_q.size() > 0) begin
            check("instr", instr, exp_instr_q.pop_front());
        end
        if (mem_req) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_req", mem_addr, 32'hFFFF_FFFF);
                mem_valid = 1'b0;
            end else begin
                check("mem_addr", mem_addr, exp_addr_q[0]);
                if (wcnt >= wait_cycles) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    wcnt = 0;
                    void'(exp_addr_q.pop_front());
                end else begin
                    mem_valid = 1'b0;
                    mem_rdata = 32'hDEAD_BEEF;
                    wcnt++;
                end
            end
        end else begin
            mem_valid = 1'b0;
            wcnt = 0;
        end
    end

    // Issue a fetch at pc_v; expects 'fills' line refills, exp_stalls stall
    // cycles, then exp_instr. flush_beat >= 0 pulses flush while that beat is requested.
    task automatic fetch(input logic [31:0] pc_v, input logic [31:0] exp_instr,
                         input int exp_stalls, input int fills, input int flush_beat);
        int n;
        bit flushed_once;
        logic [31:0] base;
        base = {pc_v[31:4], 4'h0};
        pc = pc_v;
        for (int f = 0; f < fills; f++)
            for (int b = 0; b < 4; b++)
                exp_addr_q.push_back(base + 32'(4 * b));
        exp_instr_q.push_back(exp_instr);
        n = 0;
        flushed_once = 1'b0;
        #1;
        while (stall && n < 400) begin
            if (flush_beat >= 0 && !flushed_once && mem_req &&
                mem_addr == base + 32'(4 * flush_beat)) begin
                flush = 1'b1;
                flushed_once = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
            flush = 1'b0;
            #1;
        end
        check("stall_cycles", 32'(n), 32'(exp_stalls));
        @(posedge clk);
        #2;
        if (exp_instr_q.size() != 0) begin
            check("instr_never_seen", 32'(exp_instr_q.size()), 32'h0);
            exp_instr_q.delete();
        end
        if (exp_addr_q.size() != 0) begin
            check("addr_left_over", 32'(exp_addr_q.size()), 32'h0);
            exp_addr_q.delete();
        end
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b0;
        pc        = 32'h0;
        flush     = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'h1);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        rst = 1'b1;
        #1;
        check("rel_stall", 32'(stall), 32'h1);
        check("rel_mem_req", 32'(mem_req), 32'h0);
        check("rel_mem_addr", mem_addr, 32'h0);
        check("rel_instr", instr, 32'h0);
        // pc=0 after release misses and fills line 0
        fetch(32'h0, 32'hA0, 5, 1, -1);

        // Cold miss, then hit in same line
        fetch(32'h10, 32'hA0, 5, 1, -1);
        fetch(32'h1C, 32'hA3, 0, 0, -1);
        fetch(32'h14, 32'hA1, 0, 0, -1);

        // Conflict on index 1
        fetch(32'h110, 32'hB0, 5, 1, -1);
        fetch(32'h110, 32'hB0, 0, 0, -1);
        fetch(32'h11C, 32'hB3, 0, 0, -1);
        fetch(32'h10, 32'hA0, 5, 1, -1);

        // Wait states: 3 idle cycles before each beat
        wait_cycles = 3;
        fetch(32'h24, 32'hA1, 17, 1, -1);
        wait_cycles = 0;
        fetch(32'h2C, 32'hA3, 0, 0, -1);
        fetch(32'h20, 32'hA0, 0, 0, -1);

        // Flush while idle: next access misses
        pc = 32'h10;
        #1;
        check("pre_flush_hit", 32'(stall), 32'h0);
        flush_pulse();
        check("post_flush_stall", 32'(stall), 32'h1);
        fetch(32'h10, 32'hA0, 5, 1, -1);

        // Flush during refill at beat 1: line ends invalid and refills again
        flush_pulse();
        fetch(32'h10, 32'hA0, 10, 2, 1);
        pc = 32'h24;
        #1;
        check("flush_cleared_other", 32'(stall), 32'h1);
        fetch(32'h24, 32'hA1, 5, 1, -1);

        // Reset mid-refill at beat 2
        flush_pulse();
        pc = 32'h10;
        for (int b = 0; b < 4; b++) exp_addr_q.push_back(32'h10 + 32'(4 * b));
        #1;
        n = 0;
        while (!(mem_req && mem_addr == 32'h18) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_beat2", 32'(mem_req && mem_addr == 32'h18), 32'h1);
        rst = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'h0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        check("midrst_stall", 32'(stall), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        exp_addr_q.delete();
        rst = 1'b1;
        fetch(32'h10, 32'hA0, 5, 1, -1);
        fetch(32'h1C, 32'hA3, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the FETCH stage's program counter and a slow backing instruction memory. It replaces the zero-latency `instr_mem` lookup: a hit returns the instruction combinationally in the same cycle, as `instr_mem` does today. A miss raises `stall` so the pipeline holds `PCF` and the IF/ID register, then refills one 4-word line from backing memory over a request/valid handshake.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, width of PC and backing-memory address.
- `DATA_WIDTH`, 32, instruction/word width.
- `LINES`, 16, number of cache lines (power of two).
- `WORDS_PER_LINE`, 4, words per line (power of two).

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `pc`  input  ADDRESS_WIDTH  fetch address (`PCF`); bits [1:0] ignored.
- `instr`  output  DATA_WIDTH  instruction at `pc`; valid only when `stall`=0, forced to 0 when `stall`=1.
- `stall`  output  1  1 = `instr` not valid; the pipeline must hold PC and IF/ID.
- `flush`  input  1  invalidate all lines (fence.i).
- `mem_req`  output  1  word read request to backing memory.
- `mem_addr`  output  ADDRESS_WIDTH  word-aligned request address.
- `mem_valid`  input  1  backing memory returns `mem_rdata` this cycle.
- `mem_rdata`  input  DATA_WIDTH  returned word.

## Operation
- Address split, defaults: byte [1:0], word [3:2], index [7:4], tag [31:8]. Generally word = log2(WORDS_PER_LINE) bits, index = log2(LINES) bits, tag = the remainder.
- Storage: per line, a valid bit and a tag register, both reset. Data array: LINES×WORDS_PER_LINE words, not reset.
- Hit: `valid[index] && tag[index]==pc.tag && state==IDLE`. This is combinational. `instr = data[index][word]`, `stall = !hit`.
- FSM:
  - IDLE:
    - On a miss, latch `line_base = {pc.tag, pc.index, 0}`.
    - Clear `valid[index]`.
    - Set `beat = 0`.
    - Go to REFILL.
  - REFILL:
    - `mem_req = 1`, `mem_addr = line_base + 4*beat`.
    - On each edge with `mem_valid = 1`: write `mem_rdata` to `data[idx][beat]` and increment `beat`.
    - On the edge that accepts beat WORDS_PER_LINE−1: write the tag, set valid (unless `flushed`), and return to IDLE.
  - `stall` = 1 throughout REFILL.
- Handshake:
  - `mem_req` and `mem_addr` stay stable until `mem_valid` is sampled high.
  - One outstanding word at a time. Words are fetched in order 0..3; there is no critical-word-first.
  - `mem_valid` is ignored outside REFILL.
- A `pc` change during REFILL (branch redirect) does not abort the refill. The latched line completes, and lookup then uses the current `pc`.
- `flush`:
  - Clears every valid bit at the next edge.
  - If asserted in REFILL, it also sets a sticky `flushed` flag. The line being refilled completes its handshake but is left invalid. `flushed` clears on return to IDLE.
  - `flush` in the same cycle as a final-beat accept: the line ends invalid.
- Conflict miss (same index, different tag): the old line is overwritten. There is no victim handling, since the cache is read-only.

## Timing
- Reset (async, while `rst`=0):
  - State IDLE, all valid bits 0, `beat` 0, `flushed` 0.
  - `mem_req` 0 and `mem_addr` 0, both immediately.
  - `stall` reads 1, because every lookup misses.
- Hit latency: 0 cycles (`pc` to `instr` combinational).
- Miss with zero-wait memory (`mem_valid` high whenever `mem_req` high):
  - Cycle 0: miss detected, `stall` = 1.
  - Edge 1: enter REFILL.
  - Edges 2..5: beats 0..3 accepted.
  - Cycle 5: hit, `stall` = 0.
  - Total: 5 stall cycles.
- Each wait cycle of backing memory adds one stall cycle.
- Reset asserted mid-refill aborts at once. A response already in flight is ignored after reset.

## Test plan
- Reset, then release with `pc`=0x0 → `stall`=1, `mem_req`=0, `mem_addr`=0, `instr`=0.
- Cold miss:
  - Stimulus: `pc`=0x10; zero-wait memory returns 0xA0,0xA1,0xA2,0xA3.
  - Required: `mem_addr` sequence 0x10,0x14,0x18,0x1C on consecutive cycles; `stall` high exactly 5 cycles; then `instr`=0xA0.
  - Follow-up: `pc`=0x1C gives `instr`=0xA3 with no stall.
- Conflict:
  - After the line above, `pc`=0x110 misses and refills with 0xB0..0xB3.
  - `pc`=0x110 then returns 0xB0.
  - `pc`=0x10 then misses again and re-requests 0x10.
- Wait states:
  - Stimulus: `mem_valid` delayed 3 cycles per beat.
  - Required: `mem_addr` held stable each wait; `stall` high 17 cycles (5 for zero-wait plus 3×4 for the waits); data correct.
- Flush during REFILL:
  - Assert `flush` at beat 1 of the 0x10 refill.
  - Required: handshake completes (4 beats); `stall` remains 1 afterwards and a new refill of 0x10 starts.
  - Separately, flush in IDLE after a fill: the next access to 0x10 misses.
- Reset mid-refill:
  - Stimulus: drop `rst` at beat 2.
  - Required: `mem_req` falls before the next edge. After release, `pc`=0x10 misses and the refill restarts at 0x10.
